// File: rtl/result_display_pkg.sv
// Shared types and constants for the result display: FSM states, segment codes, digit count.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package result_display_pkg;

  localparam int NUM_DIGITS = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-decimal nibbles should never appear; show them as blank rather than garbage.
  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits, one bit per cycle.
// Result lands in bcd 16 cycles after start; start is ignored while busy.
module bin2bcd_seq
  import result_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic [19:0] bcd
);

  conv_state_t state, state_nxt;
  logic [35:0] shift, shift_nxt, shift_step;
  logic [4:0]  iter, iter_nxt;
  logic [19:0] bcd_nxt;
  logic [19:0] adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj[4*i +: 4] = (shift[16+4*i +: 4] >= 4'd5) ? shift[16+4*i +: 4] + 4'd3
                                                    : shift[16+4*i +: 4];
    end
    shift_step = {adj, shift[15:0]} << 1;
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    iter_nxt  = iter;
    bcd_nxt   = bcd;
    case (state)
      ST_IDLE: begin
        if (start) begin
          shift_nxt = {20'b0, value};
          iter_nxt  = 5'd0;
          state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        shift_nxt = shift_step;
        iter_nxt  = iter + 5'd1;
        // 16th shift: publish the finished BCD field on the same edge.
        if (iter == 5'd15) begin
          bcd_nxt   = shift_step[35:16];
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      shift <= '0;
      iter  <= '0;
      bcd   <= '0;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;
      iter  <= iter_nxt;
      bcd   <= bcd_nxt;
    end
  end

  assign busy = (state == ST_CONV);

endmodule

// File: rtl/result_display.sv
// Captures the accelerator result on busy falling, converts to BCD and scans it
// over five multiplexed 7-segment digits with leading-zero blanking and a busy dash.
module result_display
  import result_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        busy_i,
  input  logic [15:0] value_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        conv_busy_o
);

  localparam logic [15:0] CNT_MAX = 16'(REFRESH_DIV - 1);

  logic        busy_q;
  logic        capture;
  logic [19:0] disp_q;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  an_nxt;
  logic [6:0]  seg_nxt;
  logic [19:0] upper;
  logic        blank;

  assign capture = busy_q & ~busy_i;

  bin2bcd_seq u_bcd (
    .clk   (clk_i),
    .rst_n (rst_i),
    .start (capture),
    .value (value_i),
    .busy  (conv_busy_o),
    .bcd   (disp_q)
  );

  // Outputs are computed from the next digit index so they change together with it.
  always_comb begin
    cnt_nxt = cnt + 16'd1;
    idx_nxt = idx;
    if (cnt == CNT_MAX) begin
      cnt_nxt = '0;
      idx_nxt = (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
    end

    an_nxt          = 8'hFF;
    an_nxt[idx_nxt] = 1'b0;

    upper = disp_q >> {idx_nxt, 2'b00};
    blank = (idx_nxt != 3'd0) && (upper == 20'd0);

    if (busy_i)     seg_nxt = SEG_DASH;
    else if (blank) seg_nxt = SEG_BLANK;
    else            seg_nxt = seg_of(upper[3:0]);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
      an_o   <= 8'hFE;
      seg_o  <= SEG_0;
    end else begin
      busy_q <= busy_i;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      an_o   <= an_nxt;
      seg_o  <= seg_nxt;
    end
  end

endmodule
